gray_stream_decoder: RTL and testbench
======================================

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 The block SHALL have one parameter: POS_W, 8, width of the signed position accumulator.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  clr  input  1  synchronous clear of pos, err_cnt and lock
  in_valid  input  1  G is sampled this cycle
  G  input  4  Gray-coded value, G[3] MSB, produced by the upstream binary-to-Gray stage
  B  output  4  registered binary equivalent of last accepted G
  out_valid  output  1  one-cycle pulse per accepted sample
  dir_up  output  1  one-cycle pulse, +1 step detected
  dir_dn  output  1  one-cycle pulse, -1 step detected
  err  output  1  one-cycle pulse, illegal (multi-bit) transition
  locked  output  1  high while state is TRACK
  pos  output  POS_W  signed step accumulator, two's complement
  err_cnt  output  4  saturating illegal-transition count

Function
REQ-004 Decode SHALL be B[3]=G[3], B[i]=B[i+1] XOR G[i] for i=2..0.
REQ-005 All outputs SHALL be registered; the response to a sample accepted at edge N SHALL appear after edge N and hold until edge N+1 (latency 1).
REQ-006 The FSM SHALL have two states: UNSYNC and TRACK.
REQ-007 In UNSYNC with in_valid=1, the block SHALL store the decoded value as reference, update B, pulse out_valid, and go to TRACK; there SHALL be no step, no err pulse, and no pos change.
REQ-008 In TRACK with in_valid=1, the block SHALL compute d=(Bnew-Bref) mod 16 and:
  d=0: no step, no pos change;
  d=1: pulse dir_up, pos+1;
  d=15: pulse dir_dn, pos-1;
  otherwise: pulse err, increment err_cnt, and go to UNSYNC.
REQ-009 For every accepted sample, B SHALL be updated and out_valid SHALL pulse. Bref SHALL be updated except on err.
REQ-010 Wrap 15->0 SHALL count as +1 and 0->15 as -1. pos SHALL wrap modulo 2^POS_W without any flag.
REQ-011 err_cnt SHALL saturate at 15.
REQ-012 With in_valid=0, the block SHALL hold state and all registers; pulse outputs SHALL be 0.
REQ-013 clr=1 SHALL zero pos and err_cnt and force UNSYNC. clr SHALL take priority over a simultaneous in_valid, which is discarded: no out_valid, and B holds.
REQ-014 dir_up, dir_dn and err SHALL be mutually exclusive.

Reset
REQ-015 rst_n=0 SHALL immediately, independent of clk, force state to UNSYNC and set B, out_valid, dir_up, dir_dn, err, locked, pos, err_cnt and Bref to 0.
REQ-016 Reset mid-sequence SHALL discard the stored reference; the first sample after release resyncs per REQ-007.

Structure
REQ-017 Package gray_pkg SHALL hold the state enum (UNSYNC, TRACK), the ERR_CNT_MAX=15 constant, and the step-delta constants (1, 15).
REQ-018 The block SHALL contain one combinational sub-module, gray_to_bin (4-bit G in, 4-bit B out), implementing REQ-004.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  V1: reset, then G=0000 -> B=0000, out_valid=1, locked=1, pos=0, no dir pulse.
  V2: G sequence 0000,0001,0011,0010 -> three dir_up pulses, final B=0011, pos=3.
  V3: sync on G=1000 (B=1111), then G=0000 -> dir_up, pos=1; then G=1000 -> dir_dn, pos=0; then G=1001 (B=1110) -> dir_dn, pos=8'hFF.
  V4: sync on G=0000, then G=0011 (B=0010) -> err=1, err_cnt=1, locked=0, pos unchanged; next G=0011 -> resync, no step.
  V5: 17 illegal transitions -> err_cnt stays 15; clr with in_valid=1 -> pos=0, err_cnt=0, locked=0, out_valid=0.
  V6: rst_n pulled low between clock edges mid-TRACK -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-coded position stream decoder.
package gray_pkg;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_t;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;
  localparam logic [3:0] STEP_UP     = 4'd1;
  localparam logic [3:0] STEP_DN     = 4'd15;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational 4-bit Gray-to-binary converter: each binary bit is the XOR
// of the binary bit above it and the Gray bit at the same position.
module gray_to_bin (
  input  logic [3:0] g,
  output logic [3:0] b
);

  always_comb begin
    b    = '0;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Decodes a Gray-coded position stream, classifies each step against the
// stored reference and accumulates a signed position with error tracking.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       G,
  output logic [3:0]       B,
  output logic             out_valid,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             err,
  output logic             locked,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       err_cnt
);

  // state  | meaning
  // UNSYNC | no valid reference; next accepted sample becomes the reference
  // TRACK  | reference held; samples are classified as hold / +1 / -1 / illegal

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       bref_q, bref_d;
  logic [3:0]       b_new;
  logic [3:0]       delta;
  logic             step_err;
  logic [3:0]       b_d;
  logic             out_valid_d, dir_up_d, dir_dn_d, err_d;
  logic [POS_W-1:0] pos_d;
  logic [3:0]       err_cnt_d;

  gray_to_bin u_gray_to_bin (
    .g (G),
    .b (b_new)
  );

  // Modulo-16 difference makes the 15->0 and 0->15 wraps look like +1 / -1.
  assign delta    = b_new - bref_q;
  assign step_err = (state_q == TRACK) && (delta != 4'd0)
                    && (delta != STEP_UP) && (delta != STEP_DN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = UNSYNC;
    end else if (in_valid) begin
      case (state_q)
        UNSYNC:  state_d = TRACK;
        TRACK:   state_d = step_err ? UNSYNC : TRACK;
        default: state_d = UNSYNC;
      endcase
    end
  end

  always_comb begin
    b_d         = B;
    bref_d      = bref_q;
    pos_d       = pos;
    err_cnt_d   = err_cnt;
    out_valid_d = 1'b0;
    dir_up_d    = 1'b0;
    dir_dn_d    = 1'b0;
    err_d       = 1'b0;
    if (clr) begin
      pos_d     = '0;
      err_cnt_d = '0;
    end else if (in_valid) begin
      b_d         = b_new;
      out_valid_d = 1'b1;
      if (state_q == UNSYNC || delta == 4'd0) begin
        bref_d = b_new;
      end else if (delta == STEP_UP) begin
        dir_up_d = 1'b1;
        pos_d    = pos + POS_ONE;
        bref_d   = b_new;
      end else if (delta == STEP_DN) begin
        dir_dn_d = 1'b1;
        pos_d    = pos - POS_ONE;
        bref_d   = b_new;
      end else begin
        // Reference is left stale on purpose; UNSYNC reloads it next sample.
        err_d = 1'b1;
        if (err_cnt != ERR_CNT_MAX) begin
          err_cnt_d = err_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      B         <= '0;
      bref_q    <= '0;
      out_valid <= 1'b0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
      err       <= 1'b0;
      pos       <= '0;
      err_cnt   <= '0;
    end else begin
      B         <= b_d;
      bref_q    <= bref_d;
      out_valid <= out_valid_d;
      dir_up    <= dir_up_d;
      dir_dn    <= dir_dn_d;
      err       <= err_d;
      pos       <= pos_d;
      err_cnt   <= err_cnt_d;
    end
  end

  assign locked = (state_q == TRACK);

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Scoreboard bench for gray_stream_decoder: directed scenarios followed by
// random stimulus, checked against a behavioural position-tracking model.
module tb_gray_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic [3:0] G;
  logic [3:0] B;
  logic       out_valid, dir_up, dir_dn, err, locked;
  logic [7:0] pos;
  logic [3:0] err_cnt;

  gray_stream_decoder #(.POS_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .G         (G),
    .B         (B),
    .out_valid (out_valid),
    .dir_up    (dir_up),
    .dir_dn    (dir_dn),
    .err       (err),
    .locked    (locked),
    .pos       (pos),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] b;
    logic       up;
    logic       dn;
    logic       er;
    logic       lk;
    logic [7:0] ps;
    logic [3:0] ec;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  bit         m_synced = 0;
  logic [3:0] m_ref    = '0;
  logic [3:0] m_b      = '0;
  logic [7:0] m_pos    = '0;
  int         m_ec     = 0;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Inverse Gray by search: the binary value whose Gray encoding matches g.
  function automatic logic [3:0] ref_decode(input logic [3:0] g);
    for (int v = 0; v < 16; v++) begin
      logic [3:0] c;
      c = v[3:0];
      if ((c ^ (c >> 1)) == g) return c;
    end
    return '0;
  endfunction

  task automatic model_accept(input logic [3:0] g);
    exp_t e;
    int   d;
    logic [3:0] bn;
    bn = ref_decode(g);
    e  = '0;
    m_b = bn;
    if (!m_synced) begin
      m_synced = 1;
      m_ref    = bn;
    end else begin
      d = (int'(bn) - int'(m_ref) + 16) % 16;
      if (d == 0) begin
        m_ref = bn;
      end else if (d == 1) begin
        e.up  = 1'b1;
        m_pos = m_pos + 8'd1;
        m_ref = bn;
      end else if (d == 15) begin
        e.dn  = 1'b1;
        m_pos = m_pos - 8'd1;
        m_ref = bn;
      end else begin
        e.er     = 1'b1;
        m_ec     = (m_ec < 15) ? m_ec + 1 : 15;
        m_synced = 0;
      end
    end
    e.b  = bn;
    e.lk = m_synced;
    e.ps = m_pos;
    e.ec = m_ec[3:0];
    q.push_back(e);
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending sample");
      end else begin
        e = q.pop_front();
        check("sb_b",       int'(B),       int'(e.b));
        check("sb_dir_up",  int'(dir_up),  int'(e.up));
        check("sb_dir_dn",  int'(dir_dn),  int'(e.dn));
        check("sb_err",     int'(err),     int'(e.er));
        check("sb_locked",  int'(locked),  int'(e.lk));
        check("sb_pos",     int'(pos),     int'(e.ps));
        check("sb_err_cnt", int'(err_cnt), int'(e.ec));
      end
    end else begin
      check("idle_pulses", int'({dir_up, dir_dn, err}), 0);
    end
  end

  task automatic send(input logic v, input logic [3:0] g);
    clr      = 1'b0;
    in_valid = v;
    G        = g;
    if (v) model_accept(g);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_clr(input logic v, input logic [3:0] g);
    clr      = 1'b1;
    in_valid = v;
    G        = g;
    m_synced = 0;
    m_pos    = '0;
    m_ec     = 0;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_pos",       int'(pos),       0);
    check("clr_err_cnt",   int'(err_cnt),   0);
    check("clr_locked",    int'(locked),    0);
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_b_hold",    int'(B),         int'(m_b));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_b"},         int'(B),         0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_pulses"},    int'({dir_up, dir_dn, err}), 0);
    check({tag, "_locked"},    int'(locked),    0);
    check({tag, "_pos"},       int'(pos),       0);
    check({tag, "_err_cnt"},   int'(err_cnt),   0);
  endtask

  initial begin
    int ups;
    int errs;
    logic [3:0] tb;
    rst_n    = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    G        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // V1
    send(1'b1, 4'b0000);
    check("v1_b",         int'(B),         0);
    check("v1_out_valid", int'(out_valid), 1);
    check("v1_locked",    int'(locked),    1);
    check("v1_pos",       int'(pos),       0);
    check("v1_dir",       int'({dir_up, dir_dn}), 0);

    // V2
    ups = 0;
    send(1'b1, 4'b0001); ups += int'(dir_up);
    send(1'b1, 4'b0011); ups += int'(dir_up);
    send(1'b1, 4'b0010); ups += int'(dir_up);
    check("v2_ups", ups,       3);
    check("v2_b",   int'(B),   3);
    check("v2_pos", int'(pos), 3);

    // V3
    do_clr(1'b0, 4'b0000);
    send(1'b1, 4'b1000);
    check("v3_sync_b", int'(B), 15);
    send(1'b1, 4'b0000);
    check("v3_wrap_up",  int'(dir_up), 1);
    check("v3_pos1",     int'(pos),    1);
    send(1'b1, 4'b1000);
    check("v3_wrap_dn",  int'(dir_dn), 1);
    check("v3_pos0",     int'(pos),    0);
    send(1'b1, 4'b1001);
    check("v3_b14",      int'(B),      14);
    check("v3_dn2",      int'(dir_dn), 1);
    check("v3_pos_ff",   int'(pos),    255);

    // V4
    do_clr(1'b0, 4'b0000);
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0011);
    check("v4_err",     int'(err),     1);
    check("v4_err_cnt", int'(err_cnt), 1);
    check("v4_locked",  int'(locked),  0);
    check("v4_pos",     int'(pos),     0);
    check("v4_b",       int'(B),       2);
    send(1'b1, 4'b0011);
    check("v4_resync_locked", int'(locked), 1);
    check("v4_resync_pulses", int'({dir_up, dir_dn, err}), 0);

    // Move pos off zero, then V5
    send(1'b1, 4'b0010);
    send(1'b1, 4'b0110);
    check("pre_v5_pos", int'(pos), 2);
    errs = 0;
    for (int i = 0; i < 17; i++) begin
      send(1'b1, 4'b0000); errs += int'(err);
      send(1'b1, 4'b0011); errs += int'(err);
    end
    check("v5_errs",    errs,          17);
    check("v5_err_cnt", int'(err_cnt), 15);
    check("v5_pos",     int'(pos),     2);
    do_clr(1'b1, 4'b0101);

    // V6
    send(1'b1, 4'b0000);
    send(1'b1, 4'b0001);
    check("v6_pre_pos", int'(pos), 1);
    send(1'b0, 4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("v6_async");
    m_synced = 0;
    m_pos    = '0;
    m_ec     = 0;
    m_b      = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 4'b0111);
    check("v6_resync_b",      int'(B),      5);
    check("v6_resync_locked", int'(locked), 1);
    check("v6_resync_pos",    int'(pos),    0);

    // Random phase
    for (int n = 0; n < 400; n++) begin
      int r;
      int k;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_clr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end else if (r < 20) begin
        send(1'b0, 4'($urandom_range(0, 15)));
      end else begin
        k = $urandom_range(0, 9);
        if (k < 4)      tb = m_b + 4'd1;
        else if (k < 7) tb = m_b - 4'd1;
        else if (k < 8) tb = m_b;
        else            tb = 4'($urandom_range(0, 15));
        send(1'b1, tb ^ (tb >> 1));
      end
    end

    repeat (3) send(1'b0, 4'b0000);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
